// File: rtl/idma_axi_w_to_obi_bridge.sv
// AXI4 write-burst responder that forwards each W beat as one OBI write,
// tracks outstanding OBI responses and returns one B response per burst.
module idma_axi_w_to_obi_bridge #(
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned IdWidth        = 4,
  parameter int unsigned MaxOutstanding = 4,
  localparam int unsigned StrbWidth     = DataWidth / 8,
  localparam int unsigned OffsetWidth   = $clog2(StrbWidth)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  // AXI AW channel
  input  logic                 aw_valid_i,
  output logic                 aw_ready_o,
  input  logic [IdWidth-1:0]   aw_id_i,
  input  logic [AddrWidth-1:0] aw_addr_i,
  input  logic [7:0]           aw_len_i,
  input  logic [2:0]           aw_size_i,
  input  logic [1:0]           aw_burst_i,
  // AXI W channel
  input  logic                 w_valid_i,
  output logic                 w_ready_o,
  input  logic [DataWidth-1:0] w_data_i,
  input  logic [StrbWidth-1:0] w_strb_i,
  input  logic                 w_last_i,
  // AXI B channel
  output logic                 b_valid_o,
  input  logic                 b_ready_i,
  output logic [IdWidth-1:0]   b_id_o,
  output logic [1:0]           b_resp_o,
  // OBI manager port
  output logic                 obi_req_o,
  input  logic                 obi_gnt_i,
  output logic [AddrWidth-1:0] obi_addr_o,
  output logic                 obi_we_o,
  output logic [StrbWidth-1:0] obi_be_o,
  output logic [DataWidth-1:0] obi_wdata_o,
  input  logic                 obi_rvalid_i,
  input  logic                 obi_err_i,
  // status
  output logic                 busy_o
);

  localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);

  localparam logic [CntWidth-1:0]  CntZero    = {CntWidth{1'b0}};
  localparam logic [CntWidth-1:0]  CntOne     = {{(CntWidth-1){1'b0}}, 1'b1};
  localparam logic [CntWidth-1:0]  CntMax     = CntWidth'(MaxOutstanding);
  localparam logic [AddrWidth-1:0] AddrZero   = {AddrWidth{1'b0}};
  localparam logic [AddrWidth-1:0] AddrOne    = {{(AddrWidth-1){1'b0}}, 1'b1};
  localparam logic [AddrWidth-1:0] WordMask   = AddrWidth'(StrbWidth - 1);
  localparam logic [1:0]           BurstIncr  = 2'b01;
  localparam logic [1:0]           BurstWrap  = 2'b10;
  localparam logic [1:0]           RespOkay   = 2'b00;
  localparam logic [1:0]           RespSlvErr = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [IdWidth-1:0]     id_q, id_d;
  logic [AddrWidth-1:0]   addr_q, addr_d;
  logic [2:0]             size_q, size_d;
  logic [1:0]             burst_q, burst_d;
  logic [7:0]             beats_left_q, beats_left_d;
  logic [CntWidth-1:0]    outst_q, outst_d;
  logic                   err_q, err_d;

  logic                   aw_hs;
  logic                   beat_gnt;
  logic                   last_beat;
  logic                   rsp_retire;
  logic [AddrWidth-1:0]   addr_step;
  logic [AddrWidth-1:0]   addr_incr;

  assign aw_hs      = aw_valid_i & aw_ready_o;
  assign beat_gnt   = obi_req_o & obi_gnt_i;
  assign last_beat  = (beats_left_q == 8'd0);
  // A response with nothing outstanding (e.g. left over from before a reset)
  // must not underflow the counter.
  assign rsp_retire = obi_rvalid_i & (outst_q != CntZero);

  // INCR address step: align down to the beat size, then advance one beat.
  assign addr_step  = AddrOne << size_q;
  assign addr_incr  = (addr_q & ~(addr_step - AddrOne)) + addr_step;

  assign busy_o = (state_q != IDLE);

  // State register with asynchronous reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (aw_hs) begin
          state_d = BURST;
        end else begin
          state_d = IDLE;
        end
      end
      BURST: begin
        if (beat_gnt && last_beat) begin
          state_d = DRAIN;
        end else begin
          state_d = BURST;
        end
      end
      DRAIN: begin
        // Leave as soon as the final response retires, even in this cycle.
        if (outst_d == CntZero) begin
          state_d = RESP;
        end else begin
          state_d = DRAIN;
        end
      end
      RESP: begin
        if (b_ready_i) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode: OBI request and W ready are combinational so a W beat is
  // consumed in the same cycle its OBI write is granted.
  always_comb begin
    aw_ready_o  = 1'b0;
    w_ready_o   = 1'b0;
    b_valid_o   = 1'b0;
    b_id_o      = {IdWidth{1'b0}};
    b_resp_o    = RespOkay;
    obi_req_o   = 1'b0;
    obi_we_o    = 1'b0;
    obi_addr_o  = AddrZero;
    obi_be_o    = {StrbWidth{1'b0}};
    obi_wdata_o = {DataWidth{1'b0}};
    case (state_q)
      IDLE: begin
        aw_ready_o = 1'b1;
      end
      BURST: begin
        obi_req_o   = w_valid_i & (outst_q < CntMax);
        obi_we_o    = 1'b1;
        obi_addr_o  = addr_q & ~WordMask;
        obi_be_o    = w_strb_i;
        obi_wdata_o = w_data_i;
        w_ready_o   = obi_req_o & obi_gnt_i;
      end
      DRAIN: begin
        obi_req_o = 1'b0;
      end
      RESP: begin
        b_valid_o = 1'b1;
        b_id_o    = id_q;
        if (err_q) begin
          b_resp_o = RespSlvErr;
        end else begin
          b_resp_o = RespOkay;
        end
      end
      default: begin
        aw_ready_o = 1'b0;
      end
    endcase
  end

  // Burst context, beat counter, outstanding counter and sticky error update.
  always_comb begin
    id_d         = id_q;
    addr_d       = addr_q;
    size_d       = size_q;
    burst_d      = burst_q;
    beats_left_d = beats_left_q;
    outst_d      = outst_q;
    err_d        = err_q;

    if (state_q == IDLE) begin
      if (aw_hs) begin
        id_d         = aw_id_i;
        addr_d       = aw_addr_i;
        size_d       = aw_size_i;
        burst_d      = aw_burst_i;
        beats_left_d = aw_len_i;
      end else begin
        beats_left_d = beats_left_q;
      end
    end else if (state_q == BURST) begin
      if (beat_gnt) begin
        // FIXED (and unsupported WRAP) keep the address.
        if (burst_q == BurstIncr) begin
          addr_d = addr_incr;
        end else begin
          addr_d = addr_q;
        end
        if (!last_beat) begin
          beats_left_d = beats_left_q - 8'd1;
        end else begin
          beats_left_d = beats_left_q;
        end
      end else begin
        addr_d = addr_q;
      end
    end else begin
      addr_d = addr_q;
    end

    if (beat_gnt && !rsp_retire) begin
      outst_d = outst_q + CntOne;
    end else if (rsp_retire && !beat_gnt) begin
      outst_d = outst_q - CntOne;
    end else begin
      outst_d = outst_q;
    end

    if (state_q == IDLE) begin
      err_d = err_q;
    end else if (state_q == RESP && b_ready_i) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q | (obi_rvalid_i & obi_err_i);
    end
  end

  // Datapath registers with asynchronous reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      id_q         <= {IdWidth{1'b0}};
      addr_q       <= AddrZero;
      size_q       <= 3'd0;
      burst_q      <= 2'b00;
      beats_left_q <= 8'd0;
      outst_q      <= CntZero;
      err_q        <= 1'b0;
    end else begin
      id_q         <= id_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      burst_q      <= burst_d;
      beats_left_q <= beats_left_d;
      outst_q      <= outst_d;
      err_q        <= err_d;
    end
  end

  // Protocol checks: unsupported bursts, oversized beats, W last alignment and
  // unexpected OBI responses.
  a_no_wrap: assert property (@(posedge clk_i) disable iff (!rst_ni)
    aw_hs |-> (aw_burst_i != BurstWrap));

  a_size_fits: assert property (@(posedge clk_i) disable iff (!rst_ni)
    aw_hs |-> (aw_size_i <= 3'(OffsetWidth)));

  a_last_match: assert property (@(posedge clk_i) disable iff (!rst_ni)
    beat_gnt |-> (w_last_i == last_beat));

  a_rsp_expected: assert property (@(posedge clk_i) disable iff (!rst_ni)
    obi_rvalid_i |-> (outst_q != CntZero));

endmodule

// File: tb/tb_idma_axi_w_to_obi_bridge.sv
// Directed bench for idma_axi_w_to_obi_bridge (MaxOutstanding = 2).
module tb_idma_axi_w_to_obi_bridge;

  logic        clk_i;
  logic        rst_ni;
  logic        aw_valid_i;
  logic        aw_ready_o;
  logic [3:0]  aw_id_i;
  logic [31:0] aw_addr_i;
  logic [7:0]  aw_len_i;
  logic [2:0]  aw_size_i;
  logic [1:0]  aw_burst_i;
  logic        w_valid_i;
  logic        w_ready_o;
  logic [31:0] w_data_i;
  logic [3:0]  w_strb_i;
  logic        w_last_i;
  logic        b_valid_o;
  logic        b_ready_i;
  logic [3:0]  b_id_o;
  logic [1:0]  b_resp_o;
  logic        obi_req_o;
  logic        obi_gnt_i;
  logic [31:0] obi_addr_o;
  logic        obi_we_o;
  logic [3:0]  obi_be_o;
  logic [31:0] obi_wdata_o;
  logic        obi_rvalid_i;
  logic        obi_err_i;
  logic        busy_o;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_addr [16];
  logic [3:0]  strb_v   [16];

  idma_axi_w_to_obi_bridge #(
    .DataWidth      (32),
    .AddrWidth      (32),
    .IdWidth        (4),
    .MaxOutstanding (2)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .aw_valid_i   (aw_valid_i),
    .aw_ready_o   (aw_ready_o),
    .aw_id_i      (aw_id_i),
    .aw_addr_i    (aw_addr_i),
    .aw_len_i     (aw_len_i),
    .aw_size_i    (aw_size_i),
    .aw_burst_i   (aw_burst_i),
    .w_valid_i    (w_valid_i),
    .w_ready_o    (w_ready_o),
    .w_data_i     (w_data_i),
    .w_strb_i     (w_strb_i),
    .w_last_i     (w_last_i),
    .b_valid_o    (b_valid_o),
    .b_ready_i    (b_ready_i),
    .b_id_o       (b_id_o),
    .b_resp_o     (b_resp_o),
    .obi_req_o    (obi_req_o),
    .obi_gnt_i    (obi_gnt_i),
    .obi_addr_o   (obi_addr_o),
    .obi_we_o     (obi_we_o),
    .obi_be_o     (obi_be_o),
    .obi_wdata_o  (obi_wdata_o),
    .obi_rvalid_i (obi_rvalid_i),
    .obi_err_i    (obi_err_i),
    .busy_o       (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] bdata(input logic [3:0] id, input int i);
    return 32'hC0DE_0000 | (32'(id) << 8) | 32'(i);
  endfunction

  // One full burst: AW, W beats with an in-order OBI responder of fixed
  // latency, then B with an optional ready stall.
  task automatic run_burst(input string nm, input logic [3:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [1:0] burst, input int lat,
                           input int err_beat, input int bstall, input logic [1:0] exp_resp,
                           input int exp_stall);
    int pend_cnt[$];
    logic pend_err[$];
    int bi = 0, ng = 0, cyc = 0, stall_cnt = 0, req_stall = 0, wr_bad = 0, hold_bad = 0;
    int last_rv = -100, bv_cyc = -50;
    logic done = 1'b0;
    logic [3:0] bid0 = 4'h0;
    logic [1:0] bresp0 = 2'b00;

    aw_valid_i = 1'b1; aw_id_i = id; aw_addr_i = addr; aw_len_i = len;
    aw_size_i = 3'd2; aw_burst_i = burst;
    w_valid_i = 1'b1; w_data_i = bdata(id, 0); w_strb_i = strb_v[0]; w_last_i = (len == 8'd0);
    obi_gnt_i = 1'b1; obi_rvalid_i = 1'b0; obi_err_i = 1'b0; b_ready_i = 1'b0;
    @(negedge clk_i);
    chk_eq({nm, ".aw_ready"}, 32'(aw_ready_o), 32'd1);
    chk_eq({nm, ".no_req_in_aw"}, 32'({obi_req_o, w_ready_o}), 32'd0);
    @(posedge clk_i); #1;
    aw_valid_i = 1'b0;

    while (!done && cyc < 300) begin
      obi_rvalid_i = (pend_cnt.size() > 0) && (pend_cnt[0] == 0);
      obi_err_i    = obi_rvalid_i ? pend_err[0] : 1'b0;
      w_valid_i    = (bi <= int'(len));
      w_data_i     = bdata(id, bi);
      w_strb_i     = (bi < 16) ? strb_v[bi] : 4'h0;
      w_last_i     = (bi == int'(len));
      b_ready_i    = (stall_cnt >= bstall);
      @(negedge clk_i);
      if (cyc == 0) chk_eq({nm, ".busy"}, 32'(busy_o), 32'd1);
      if (w_ready_o !== (obi_req_o & obi_gnt_i)) wr_bad++;
      if (w_valid_i && !obi_req_o) req_stall++;
      if (obi_req_o && obi_gnt_i) begin
        if (ng < 16) begin
          chk_eq($sformatf("%s.addr%0d", nm, ng), obi_addr_o, exp_addr[ng]);
          chk_eq($sformatf("%s.be%0d", nm, ng), 32'(obi_be_o), 32'(strb_v[ng]));
          chk_eq($sformatf("%s.wdata%0d", nm, ng), obi_wdata_o, bdata(id, ng));
          chk_eq($sformatf("%s.we%0d", nm, ng), 32'(obi_we_o), 32'd1);
        end
        pend_cnt.push_back(lat);
        pend_err.push_back(ng == err_beat);
        ng++;
        bi++;
      end
      if (obi_rvalid_i) begin
        void'(pend_cnt.pop_front());
        void'(pend_err.pop_front());
        last_rv = cyc;
      end
      if (b_valid_o) begin
        if (bv_cyc < 0) begin
          bv_cyc = cyc; bid0 = b_id_o; bresp0 = b_resp_o;
        end else if (b_id_o !== bid0 || b_resp_o !== bresp0) begin
          hold_bad++;
        end
        if (aw_ready_o) hold_bad++;
        if (b_ready_i) done = 1'b1;
        else stall_cnt++;
      end
      foreach (pend_cnt[k]) pend_cnt[k]--;
      @(posedge clk_i); #1;
      cyc++;
    end

    chk_eq({nm, ".finished"}, 32'(done), 32'd1);
    chk_eq({nm, ".beats"}, 32'(ng), 32'(len) + 32'd1);
    chk_eq({nm, ".req_stalls"}, 32'(req_stall), 32'(exp_stall));
    chk_eq({nm, ".w_ready_eq_gnt"}, 32'(wr_bad), 32'd0);
    chk_eq({nm, ".b_after_rvalid"}, 32'(bv_cyc - last_rv), 32'd1);
    chk_eq({nm, ".b_id"}, 32'(bid0), 32'(id));
    chk_eq({nm, ".b_resp"}, 32'(bresp0), 32'(exp_resp));
    chk_eq({nm, ".b_hold"}, 32'(hold_bad), 32'd0);
    chk_eq({nm, ".b_stall_len"}, 32'(stall_cnt), 32'(bstall));

    b_ready_i = 1'b0; w_valid_i = 1'b0; obi_rvalid_i = 1'b0; obi_err_i = 1'b0;
    @(negedge clk_i);
    chk_eq({nm, ".aw_ready_after_b"}, 32'(aw_ready_o), 32'd1);
    chk_eq({nm, ".idle_after_b"}, 32'({busy_o, b_valid_o}), 32'd0);
    @(posedge clk_i); #1;
  endtask

  task automatic set_incr(input logic [31:0] a0, input int n);
    for (int i = 0; i < 16; i++) begin
      exp_addr[i] = a0 + 32'(4 * i);
      strb_v[i]   = 4'hF;
    end
    exp_addr[n] = 32'hDEAD_BEEF;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b0; aw_valid_i = 1'b0; aw_id_i = 4'h0; aw_addr_i = 32'h0; aw_len_i = 8'h0;
    aw_size_i = 3'd0; aw_burst_i = 2'b00; w_valid_i = 1'b0; w_data_i = 32'h0; w_strb_i = 4'h0;
    w_last_i = 1'b0; b_ready_i = 1'b0; obi_gnt_i = 1'b0; obi_rvalid_i = 1'b0; obi_err_i = 1'b0;
    for (int i = 0; i < 16; i++) begin
      exp_addr[i] = 32'h0;
      strb_v[i]   = 4'hF;
    end
    #2;
    chk_eq("reset.aw_ready", 32'(aw_ready_o), 32'd1);
    chk_eq("reset.others", 32'({w_ready_o, b_valid_o, obi_req_o, obi_we_o, busy_o}), 32'd0);
    chk_eq("reset.b_id_resp", 32'({b_id_o, b_resp_o}), 32'd0);
    chk_eq("reset.obi_bus", obi_addr_o | obi_wdata_o | 32'(obi_be_o), 32'd0);
    repeat (3) @(posedge clk_i);
    #1; rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Single beat, rvalid two cycles after grant.
    set_incr(32'h100, 1);
    run_burst("single", 4'h3, 32'h100, 8'd0, 2'b01, 2, -1, 0, 2'b00, 0);

    // Unaligned INCR start: first beat word-aligned down, then +4 per beat.
    set_incr(32'h100, 4);
    strb_v[0] = 4'hC; strb_v[1] = 4'hF; strb_v[2] = 4'h6; strb_v[3] = 4'h3;
    run_burst("incr_unal", 4'h5, 32'h102, 8'd3, 2'b01, 2, -1, 0, 2'b00, 1);

    // Backpressure: only two writes in flight, responses held back 5 cycles.
    set_incr(32'h040, 4);
    run_burst("backpress", 4'h6, 32'h040, 8'd3, 2'b01, 5, -1, 0, 2'b00, 4);

    // Error on the second response gives SLVERR.
    set_incr(32'h180, 3);
    run_burst("error", 4'h9, 32'h180, 8'd2, 2'b01, 2, 1, 0, 2'b10, 1);

    // Clean burst afterwards must be OKAY again.
    set_incr(32'h1C0, 1);
    run_burst("clean", 4'hA, 32'h1C0, 8'd0, 2'b01, 1, -1, 0, 2'b00, 0);

    // B ready held low for 4 cycles.
    set_incr(32'h1D0, 2);
    run_burst("b_stall", 4'hC, 32'h1D0, 8'd1, 2'b01, 1, -1, 4, 2'b00, 0);

    // FIXED burst: every beat to the same word.
    for (int i = 0; i < 16; i++) begin
      exp_addr[i] = 32'h200;
      strb_v[i]   = 4'hF;
    end
    strb_v[1] = 4'h5;
    run_burst("fixed", 4'h7, 32'h200, 8'd2, 2'b00, 1, -1, 0, 2'b00, 0);

    // Asynchronous reset in the middle of a burst.
    aw_valid_i = 1'b1; aw_id_i = 4'hB; aw_addr_i = 32'h300; aw_len_i = 8'd3;
    aw_size_i = 3'd2; aw_burst_i = 2'b01; w_valid_i = 1'b0; obi_gnt_i = 1'b1;
    @(posedge clk_i); #1;
    aw_valid_i = 1'b0;
    w_valid_i = 1'b1; w_data_i = 32'h1111_0000; w_strb_i = 4'hF; w_last_i = 1'b0;
    @(negedge clk_i);
    chk_eq("rst_mid.req_before", 32'(obi_req_o), 32'd1);
    chk_eq("rst_mid.addr_before", obi_addr_o, 32'h300);
    @(posedge clk_i); #1;
    w_data_i = 32'h1111_0001;
    #2;
    rst_ni = 1'b0;
    #1;
    chk_eq("rst_mid.aw_ready", 32'(aw_ready_o), 32'd1);
    chk_eq("rst_mid.req", 32'({obi_req_o, w_ready_o}), 32'd0);
    chk_eq("rst_mid.b_valid", 32'(b_valid_o), 32'd0);
    chk_eq("rst_mid.busy", 32'(busy_o), 32'd0);
    @(posedge clk_i); #1;
    w_valid_i = 1'b0;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Normal operation after the reset.
    set_incr(32'h404, 1);
    run_burst("post_rst", 4'h1, 32'h404, 8'd0, 2'b01, 3, -1, 0, 2'b00, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
